// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the BPSK receive frame parser.
// The CRC helper is only used when RX_FRAME_CRC_EN is defined.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CRC,
        ST_DONE
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int         BYTE_W    = 8;

    // One MSB-first CRC-8 step for a single incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/rx_frame_parser_crc8_serial.sv
// Bit-serial CRC-8 accumulator. 'clr' reloads the init value; when 'clr'
// and 'en' coincide the incoming bit is folded into a fresh init value so
// the first header bit of a frame is never lost.
module crc8_serial
    import rx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [7:0] crc
);

    // Accumulate one bit per enabled cycle, restarting from init on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_step(clr ? CRC8_INIT : crc, d);
        end else if (clr) begin
            crc <= CRC8_INIT;
        end
    end

endmodule

// File: rtl/rx_frame_parser.sv
// Receive frame parser behind the BPSK boundary detector: removes the phase
// ambiguity, parses length header and payload, emits bytes and signals the
// end of each frame back to the detector.
// Optional feature macro: RX_FRAME_CRC_EN (appends and checks a CRC-8 trailer).
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int MAX_LEN   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BPSK,
    input  logic                 BD_flag,
    input  logic                 BD_sgn,
    output logic                 disassert_BD,
    output logic [7:0]           rx_data,
    output logic                 rx_vld,
    output logic                 rx_sof,
    output logic                 rx_eof,
    output logic [LEN_WIDTH-1:0] rx_len,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 crc_ok
);

    localparam int SW = (LEN_WIDTH > BYTE_W) ? LEN_WIDTH : BYTE_W;
    localparam int CW = $clog2(SW);

`ifdef RX_FRAME_CRC_EN
    localparam state_t PAYLOAD_END = ST_CRC;
`else
    localparam state_t PAYLOAD_END = ST_DONE;
`endif

    state_t               state;
    state_t               state_nxt;
    logic [SW-2:0]        shift_q;
    logic [CW-1:0]        bit_cnt;
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic                 d;
    logic [LEN_WIDTH-1:0] len_word;
    logic [7:0]           byte_word;
    logic                 len_last;
    logic                 byte_last;
    logic                 last_byte;
    logic                 len_bad;

    // BD_sgn=1 leaves the symbol as-is, BD_sgn=0 inverts it.
    assign d         = BPSK ~^ BD_sgn;
    assign len_word  = {shift_q[LEN_WIDTH-2:0], d};
    assign byte_word = {shift_q[6:0], d};
    assign len_last  = (bit_cnt == CW'(LEN_WIDTH - 1));
    assign byte_last = (bit_cnt == CW'(BYTE_W - 1));
    assign last_byte = (byte_cnt == rx_len - LEN_WIDTH'(1));
    assign len_bad   = (len_word == '0) || (len_word > LEN_WIDTH'(MAX_LEN));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a dropped BD_flag anywhere inside a frame aborts it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (BD_flag) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (!BD_flag)     state_nxt = ST_IDLE;
                else if (len_last) state_nxt = len_bad ? ST_DONE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (!BD_flag)                   state_nxt = ST_IDLE;
                else if (byte_last && last_byte) state_nxt = PAYLOAD_END;
            end
`ifdef RX_FRAME_CRC_EN
            ST_CRC: begin
                if (!BD_flag)      state_nxt = ST_IDLE;
                else if (byte_last) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (!BD_flag) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift/count datapath and the registered one-cycle output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            rx_data      <= '0;
            rx_len       <= '0;
            rx_vld       <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            disassert_BD <= 1'b0;
        end else begin
            rx_vld       <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            disassert_BD <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (BD_flag) begin
                        shift_q <= {{(SW-2){1'b0}}, d};
                        bit_cnt <= CW'(1);
                    end
                end
                ST_LEN: begin
                    if (!BD_flag) begin
                        frame_err <= 1'b1;
                    end else begin
                        shift_q <= {shift_q[SW-3:0], d};
                        if (len_last) begin
                            rx_len   <= len_word;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            if (len_bad) begin
                                frame_err    <= 1'b1;
                                disassert_BD <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!BD_flag) begin
                        frame_err <= 1'b1;
                    end else begin
                        shift_q <= {shift_q[SW-3:0], d};
                        if (byte_last) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + LEN_WIDTH'(1);
                            rx_data  <= byte_word;
                            rx_vld   <= 1'b1;
                            rx_sof   <= (byte_cnt == '0);
                            rx_eof   <= last_byte;
`ifndef RX_FRAME_CRC_EN
                            if (last_byte) begin
                                frame_done   <= 1'b1;
                                disassert_BD <= 1'b1;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
`ifdef RX_FRAME_CRC_EN
                ST_CRC: begin
                    if (!BD_flag) begin
                        frame_err <= 1'b1;
                    end else if (byte_last) begin
                        bit_cnt      <= '0;
                        frame_done   <= 1'b1;
                        disassert_BD <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef RX_FRAME_CRC_EN
    logic [7:0] crc;

    crc8_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .en  (BD_flag && (state != ST_DONE)),
        .d   (d),
        .crc (crc)
    );

    // The CRC register freezes in DONE, so its residue is stable while frame_done is high.
    assign crc_ok = (state == ST_DONE) && (crc == 8'h00);
`else
    assign crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: the stimulus side predicts every
// output event from frame-level rules, a monitor pops and compares.
module tb_rx_frame_parser;

    localparam int MAX_LEN = 64;
`ifdef RX_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       BPSK;
    logic       BD_flag;
    logic       BD_sgn;
    logic       disassert_BD;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_sof;
    logic       rx_eof;
    logic [7:0] rx_len;
    logic       frame_done;
    logic       frame_err;
    logic       crc_ok;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       done;
        logic       err;
        logic       dis;
        logic       crc;
        logic [7:0] len;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  passes = 0;

    rx_frame_parser #(.LEN_WIDTH(8), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .BPSK         (BPSK),
        .BD_flag      (BD_flag),
        .BD_sgn       (BD_sgn),
        .disassert_BD (disassert_BD),
        .rx_data      (rx_data),
        .rx_vld       (rx_vld),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_len       (rx_len),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .crc_ok       (crc_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bytewise reference CRC-8 (poly 0x07, init 0x00, MSB first).
    function automatic logic [7:0] crc8_of(input logic [7:0] q[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (q[i]) begin
            c = c ^ q[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s got=%02h expected=%02h", name, act, exp);
    endtask

    // Monitor: every cycle with any strobe high must match the next predicted event.
    initial begin
        ev_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (!rst && (rx_vld || frame_done || frame_err || disassert_BD)) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("[TB] FAIL unexpected_event vld=%0b data=%02h eof=%0b done=%0b err=%0b dis=%0b at %0t",
                             rx_vld, rx_data, rx_eof, frame_done, frame_err, disassert_BD, $time);
                end else begin
                    e  = expq.pop_front();
                    ok = (rx_vld === e.vld) && (rx_sof === e.sof) && (rx_eof === e.eof) &&
                         (frame_done === e.done) && (frame_err === e.err) &&
                         (disassert_BD === e.dis) && (rx_len === e.len) &&
                         (!e.vld || rx_data === e.data) && (!e.done || crc_ok === e.crc);
                    if (ok) passes++;
                    else $display("[TB] FAIL event got vld=%0b data=%02h sof=%0b eof=%0b done=%0b err=%0b dis=%0b len=%0d crc=%0b expected vld=%0b data=%02h sof=%0b eof=%0b done=%0b err=%0b dis=%0b len=%0d crc=%0b at %0t",
                                  rx_vld, rx_data, rx_sof, rx_eof, frame_done, frame_err, disassert_BD, rx_len, crc_ok,
                                  e.vld, e.data, e.sof, e.eof, e.done, e.err, e.dis, e.len, e.crc, $time);
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input logic sgn);
        @(posedge clk);
        #1;
        BD_flag = 1'b1;
        BD_sgn  = sgn;
        BPSK    = sgn ? b : ~b;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            BD_flag = 1'b0;
            BPSK    = 1'($urandom);
            BD_sgn  = 1'($urandom);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_rx_vld", {7'd0, rx_vld}, 8'h00);
        check_output("rst_rx_sof", {7'd0, rx_sof}, 8'h00);
        check_output("rst_rx_eof", {7'd0, rx_eof}, 8'h00);
        check_output("rst_frame_done", {7'd0, frame_done}, 8'h00);
        check_output("rst_frame_err", {7'd0, frame_err}, 8'h00);
        check_output("rst_disassert", {7'd0, disassert_BD}, 8'h00);
        check_output("rst_rx_data", rx_data, 8'h00);
        check_output("rst_rx_len", rx_len, 8'h00);
        check_output("rst_crc_ok", {7'd0, crc_ok}, CRC_ON ? 8'h00 : 8'h01);
    endtask

    // mode 0: complete frame, 1: BD_flag drops after 'cut' payload bits,
    // 2: async reset after 'cut' payload bits. 'flip' inverts one payload bit on air.
    task automatic apply_stimulus(input logic [7:0] len_f, input logic [7:0] pay[$], input logic sgn,
                                  input int mode, input int cut, input int flip);
        logic [7:0] body[$];
        logic [7:0] rxp[$];
        logic [7:0] all_rx[$];
        logic [7:0] trailer;
        logic [7:0] tmp;
        logic       bad;
        int         L;
        int         nbits;
        ev_t        e;
        L    = int'(len_f);
        body = pay;
        body.push_front(len_f);
        trailer = crc8_of(body);
        rxp = pay;
        if (flip >= 0) begin
            tmp = rxp[flip / 8];
            tmp = tmp ^ (8'h80 >> (flip % 8));
            rxp[flip / 8] = tmp;
        end
        bad   = (L == 0) || (L > MAX_LEN);
        nbits = (mode == 0) ? 8 * L : cut;
        if (bad) begin
            e = '0; e.err = 1'b1; e.dis = 1'b1; e.len = len_f;
            expq.push_back(e);
        end else begin
            for (int i = 0; i < nbits / 8; i++) begin
                e = '0; e.vld = 1'b1; e.data = rxp[i]; e.len = len_f;
                e.sof = (i == 0);
                e.eof = (mode == 0) && (i == L - 1);
                if (e.eof && !CRC_ON) begin
                    e.done = 1'b1; e.dis = 1'b1; e.crc = 1'b1;
                end
                expq.push_back(e);
            end
            if (mode == 0 && CRC_ON) begin
                all_rx = rxp;
                all_rx.push_front(len_f);
                all_rx.push_back(trailer);
                e = '0; e.done = 1'b1; e.dis = 1'b1; e.len = len_f;
                e.crc = (crc8_of(all_rx) == 8'h00);
                expq.push_back(e);
            end
            if (mode == 1) begin
                e = '0; e.err = 1'b1; e.len = len_f;
                expq.push_back(e);
            end
        end
        for (int b = 7; b >= 0; b--) drive_bit(len_f[b], sgn);
        if (!bad) begin
            for (int i = 0; i < nbits; i++) begin
                tmp = rxp[i / 8];
                drive_bit(tmp[7 - (i % 8)], sgn);
            end
            if (mode == 0 && CRC_ON)
                for (int b = 7; b >= 0; b--) drive_bit(trailer[b], sgn);
        end
        if (bad || mode == 0) begin
            drive_bit(1'($urandom), sgn);
            drive_bit(1'($urandom), sgn);
            idle_cycles($urandom_range(1, 3));
        end else if (mode == 1) begin
            idle_cycles($urandom_range(1, 3));
        end else begin
            @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            check_reset_outputs();
            @(negedge clk);
            BD_flag = 1'b0;
            rst     = 1'b0;
            idle_cycles(2);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int         guard;
        int         L;
        int         r;
        int         mode;
        int         flip;
        rst     = 1'b0;
        BPSK    = 1'b0;
        BD_flag = 1'b0;
        BD_sgn  = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
        apply_stimulus(8'h02, q, 1'b1, 0, 0, -1);
        apply_stimulus(8'h02, q, 1'b0, 0, 0, -1);
        q.delete();
        apply_stimulus(8'h00, q, 1'b1, 0, 0, -1);
        apply_stimulus(8'h41, q, 1'b0, 0, 0, -1);
        apply_stimulus(8'hFF, q, 1'b1, 0, 0, -1);
        for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
        apply_stimulus(8'h40, q, 1'b1, 0, 0, -1);
        q.delete(); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
        apply_stimulus(8'h03, q, 1'b1, 1, 12, -1);
        q.delete(); q.push_back(8'h31);
        apply_stimulus(8'h01, q, 1'b1, 0, 0, -1);
        apply_stimulus(8'h01, q, 1'b0, 0, 0, 3);
        q.delete(); q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE);
        apply_stimulus(8'h03, q, 1'b1, 2, 12, -1);
        q.delete(); q.push_back(8'h5A); q.push_back(8'hC3);
        apply_stimulus(8'h02, q, 1'b0, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            L = $urandom_range(1, 6);
            q.delete();
            for (int i = 0; i < L; i++) q.push_back(8'($urandom));
            r    = $urandom_range(0, 9);
            mode = (r < 2) ? 1 : 0;
            flip = (r == 9) ? int'($urandom_range(0, 8 * L - 1)) : -1;
            if (r == 8) apply_stimulus(8'($urandom_range(65, 255)), q, 1'($urandom), 0, 0, -1);
            else apply_stimulus(8'(L), q, 1'($urandom), mode, $urandom_range(1, 8 * L - 1), flip);
        end

        guard = 0;
        while (expq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (expq.size() == 0) passes++;
        else $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0 pending", expq.size());
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
